// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock,
// with start/busy/done handshake and optional sign+magnitude handling.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3,
    parameter int SIGNED    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Per-digit correction: any digit >= 5 would reach >= 10 after doubling.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t                 state_q,   state_d;
    logic [BIN_WIDTH-1:0]   op_q,      op_d;
    logic [BCD_W-1:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic                   sticky_q,  sticky_d;
    logic                   sign_lat_q, sign_lat_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic [BCD_W-1:0]       bcd_q,     bcd_d;
    logic                   sign_q,    sign_d;
    logic                   ovf_q,     ovf_d;

    logic [BCD_W-1:0]       adj_s;
    logic [BCD_W-1:0]       shifted_s;
    logic [BIN_WIDTH-1:0]   mag_s;
    logic                   neg_s;

    // Next-state and datapath computation for the converter.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        sign_lat_d = sign_lat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        ovf_d      = ovf_q;

        adj_s     = add3_digits(scratch_q);
        shifted_s = {adj_s[BCD_W-2:0], op_q[BIN_WIDTH-1]};

        if (SIGNED != 0) begin
            neg_s = bin_in[BIN_WIDTH-1];
        end else begin
            neg_s = 1'b0;
        end
        // -2^(N-1) negates to itself, which reads correctly as unsigned 2^(N-1).
        if (neg_s) begin
            mag_s = ~bin_in + {{(BIN_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_s = bin_in;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = mag_s;
                    sign_lat_d = neg_s;
                    scratch_d  = {BCD_W{1'b0}};
                    sticky_d   = 1'b0;
                    cnt_d      = CNT_W'(BIN_WIDTH);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                scratch_d = shifted_s;
                op_d      = {op_q[BIN_WIDTH-2:0], 1'b0};
                sticky_d  = sticky_q | adj_s[BCD_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted_s;
                    ovf_d   = sticky_q | adj_s[BCD_W-1];
                    sign_d  = sign_lat_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= {BIN_WIDTH{1'b0}};
            scratch_q  <= {BCD_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            sticky_q   <= 1'b0;
            sign_lat_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= {BCD_W{1'b0}};
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            sign_lat_q <= sign_lat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign sign_out = sign_q;
    assign overflow = ovf_q;

endmodule
